// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the PC to the icache, hands each fetched
// word to the fetch/decode latch, and sequences redirects and halt.
//
// Handoff protocol: valid_o is a single-cycle strobe that loads the
// fetch/decode latch. There is no ready signal. Back-pressure is the
// stall input. While stall=1 no word is handed off, the PC holds, and the
// same address is fetched again. instr_o, npc_o and curr_pc_o are zero
// whenever valid_o=0. flush_o clears the latch in every cycle where a
// redirect is accepted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic [31:0] curr_pc_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;

  logic        active;
  logic        take_halt;
  logic        take_redir;
  logic        handoff;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Decode this cycle's events. Halt outranks redirect, and redirect outranks handoff.
  always_comb begin
    active     = !RST && (state != HALTED);
    take_halt  = active && halt;
    take_redir = active && !halt && redirect;
    handoff    = active && (state == RUN) && ihit && !stall && !redirect && !halt;
    target     = {redirect_pc[31:2], 2'b00};
    pc_plus4   = pc + 32'd4;
  end

  assign iREN      = active;
  assign iaddr     = pc;
  assign valid_o   = handoff;
  assign flush_o   = take_redir;
  assign instr_o   = handoff ? iload    : 32'd0;
  assign curr_pc_o = handoff ? pc       : 32'd0;
  assign npc_o     = handoff ? pc_plus4 : 32'd0;
  assign dbg_state = state;

  // Update the PC, the pending redirect target and the fetch state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      pc      <= {RESET_PC[31:2], 2'b00};
      pend_pc <= 32'd0;
    end else if (take_halt) begin
      state <= HALTED;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            if (ihit) begin
              pc <= target;
            end else begin
              // A miss is still outstanding. Keep iaddr stable until it returns.
              pend_pc <= target;
              state   <= DRAIN;
            end
          end else if (ihit && !stall) begin
            pc <= pc_plus4;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pend_pc <= target;
          end else if (ihit) begin
            // The returned word belongs to the old path and is dropped.
            pc    <= pend_pc;
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 SHALL provide port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port ihit  input  1  icache has returned the word at iaddr this cycle.
REQ-005 SHALL provide port iload  input  32  instruction word from icache, valid when ihit=1.
REQ-006 SHALL provide port iREN  output  1  instruction read request.
REQ-007 SHALL provide port iaddr  output  32  instruction fetch address.
REQ-008 SHALL provide port stall  input  1  downstream freeze; no PC advance, no handoff.
REQ-009 SHALL provide port redirect  input  1  branch/jump resolved taken; refetch from redirect_pc.
REQ-010 SHALL provide port redirect_pc  input  32  redirect target.
REQ-011 SHALL provide port halt  input  1  halt decoded downstream; stop fetching.
REQ-012 SHALL provide port instr_o  output  32  fetched instruction to fetch/decode latch instr_i.
REQ-013 SHALL provide port npc_o  output  32  curr_pc_o+4 to latch npc_i.
REQ-014 SHALL provide port curr_pc_o  output  32  address of instr_o to latch curr_pc_i.
REQ-015 SHALL provide port valid_o  output  1  handoff strobe, drives latch en.
REQ-016 SHALL provide port flush_o  output  1  drives latch flush.

Function
REQ-017 SHALL hold a 32-bit PC register; iaddr SHALL equal PC combinationally; PC[1:0] SHALL always be 0 (redirect_pc[1:0] ignored).
REQ-018 SHALL implement states RUN, DRAIN, HALTED in a registered state machine.
REQ-019 iREN SHALL be 1 in RUN and DRAIN, 0 in HALTED and in any cycle with RST=1.
REQ-020 In RUN, handoff SHALL occur when ihit=1, stall=0, redirect=0: valid_o=1, instr_o=iload, curr_pc_o=PC, npc_o=PC+4; next PC=PC+4.
REQ-021 In RUN with ihit=1 and stall=1 (no redirect): valid_o=0, PC holds; same fetch is repeated next cycle.
REQ-022 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no error indication.
REQ-023 Redirect in RUN with ihit=1: flush_o=1, valid_o=0, next PC=redirect_pc, stay RUN; redirect overrides stall.
REQ-024 Redirect in RUN with ihit=0 (miss outstanding): flush_o=1, valid_o=0, target captured in pending register, PC held stable, state -> DRAIN.
REQ-025 In DRAIN: iaddr held; on ihit=1 the returned word SHALL be discarded (valid_o=0), next PC=pending target, state -> RUN.
REQ-026 A further redirect in DRAIN SHALL overwrite the pending target, assert flush_o, remain DRAIN.
REQ-027 halt=1 SHALL move the block to HALTED next cycle from any state, with priority over redirect and handoff; valid_o=0 that cycle.
REQ-028 HALTED SHALL be sticky until RST; redirect, stall, ihit ignored; valid_o=0, flush_o=0.
REQ-029 When valid_o=0, instr_o, npc_o, curr_pc_o SHALL be 0.
REQ-030 flush_o SHALL be 1 only in cycles where redirect=1 is accepted (RUN or DRAIN, halt=0).

Reset
REQ-031 With RST=1 at a rising edge: PC=RESET_PC, state=RUN, pending target=0.
REQ-032 While RST=1: iREN=0, valid_o=0, flush_o=0, instr_o/npc_o/curr_pc_o=0; reset mid-DRAIN or in HALTED SHALL discard all state.

Verification
REQ-033 Reset, then ihit=1 every cycle, iload=PC-tagged words -> valid_o=1 each cycle, curr_pc_o 0,4,8,12, npc_o 4,8,12,16.
REQ-034 PC=0x10, ihit=1, stall=1 for 3 cycles -> valid_o=0, iaddr=0x10 throughout; stall drop -> handoff curr_pc_o=0x10.
REQ-035 PC=0x20, ihit=0, redirect=1 redirect_pc=0x100 -> flush_o=1, iaddr stays 0x20 until ihit; that word dropped; next iaddr=0x100.
REQ-036 PC=0x40, ihit=1, redirect=1 redirect_pc=0x203 with stall=1 -> flush_o=1, valid_o=0, next iaddr=0x200.
REQ-037 halt=1 with redirect=1 same cycle -> HALTED, iREN=0, flush_o=0; later redirects ignored; RST -> iaddr=RESET_PC.
REQ-038 PC=0xFFFF_FFFC, ihit=1 -> npc_o=0, next iaddr=0x0000_0000.
